// File: rtl/cmd_rx_if.sv
// cmd_rx_if: bundles the byte-stream input handshake, the decoded memory
// request handshake and the error pulse of the command parser.
//   rx_data/rx_valid/rx_ready : incoming byte stream (valid/ready)
//   mreq_valid/mreq_ready     : decoded request handshake
//   mreq_tag/wr/aincr/wfmt/wcnt/addr : decoded request fields
//   err                       : one-cycle pulse on bad header or timeout
// Modports: slave = the parser, master = byte source plus request consumer.
interface cmd_rx_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mreq_valid;
    logic        mreq_ready;
    logic [7:0]  mreq_tag;
    logic        mreq_wr;
    logic        mreq_aincr;
    logic [2:0]  mreq_wfmt;
    logic [7:0]  mreq_wcnt;
    logic [23:0] mreq_addr;
    logic        err;

    modport slave (
        input  rx_data, rx_valid, mreq_ready,
        output rx_ready, mreq_valid, mreq_tag, mreq_wr, mreq_aincr,
               mreq_wfmt, mreq_wcnt, mreq_addr, err
    );

    modport master (
        output rx_data, rx_valid, mreq_ready,
        input  rx_ready, mreq_valid, mreq_tag, mreq_wr, mreq_aincr,
               mreq_wfmt, mreq_wcnt, mreq_addr, err
    );
endinterface

// File: rtl/cmd_rx.sv
// cmd_rx: parses a 6-byte command frame (HDR, TAG, WCNT, ADDR[23:16],
// ADDR[15:8], ADDR[7:0]) from a byte stream into one memory request.
// Bad headers are dropped with an error pulse; a frame that stalls for
// TIMEOUT cycles between bytes is abandoned with an error pulse
// (TIMEOUT = 0 disables this). While a request waits for acceptance the
// byte input is back-pressured.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : cmd_rx_if.slave (byte input, request output, err pulse)
module cmd_rx #(
    parameter int TIMEOUT = 1000
) (
    input  logic      clk,
    input  logic      rst,
    cmd_rx_if.slave   bus
);

    // A 1-bit counter is kept when the timeout is disabled so the vector
    // never collapses to zero width.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TAG  = 3'd1,
        ST_WCNT = 3'd2,
        ST_A2   = 3'd3,
        ST_A1   = 3'd4,
        ST_A0   = 3'd5,
        ST_HOLD = 3'd6
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          rx_ready_r;
    logic          mreq_valid_r;
    logic          err_r;
    logic [7:0]    tag_r;
    logic          wr_r;
    logic          aincr_r;
    logic [2:0]    wfmt_r;
    logic [7:0]    wcnt_r;
    logic [23:0]   addr_r;

    logic          accept_s;
    logic          hdr_ok_s;
    logic [CW-1:0] cnt_inc_s;
    logic          expire_s;

    // Byte acceptance, header validity and saturating timeout arithmetic.
    always_comb begin
        accept_s  = bus.rx_valid && rx_ready_r;
        hdr_ok_s  = bus.rx_data[7] && (bus.rx_data[4:3] == 2'b00);
        cnt_inc_s = (cnt_r == CNT_LIMIT) ? cnt_r : (cnt_r + CNT_ONE);
        // Expiry is judged on the value the counter would take this edge,
        // so an accepted byte on that same edge takes priority.
        expire_s  = (TIMEOUT != 0) && (cnt_inc_s == CNT_LIMIT);
    end

    // Frame-parsing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            rx_ready_r   <= 1'b0;
            mreq_valid_r <= 1'b0;
            err_r        <= 1'b0;
            tag_r        <= 8'h00;
            wr_r         <= 1'b0;
            aincr_r      <= 1'b0;
            wfmt_r       <= 3'b000;
            wcnt_r       <= 8'h00;
            addr_r       <= 24'h000000;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Also the path that raises rx_ready after reset.
                    rx_ready_r <= 1'b1;
                    cnt_r      <= CNT_ZERO;
                    if (accept_s) begin
                        if (hdr_ok_s) begin
                            wr_r    <= bus.rx_data[6];
                            aincr_r <= bus.rx_data[5];
                            wfmt_r  <= bus.rx_data[2:0];
                            state_r <= ST_TAG;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_TAG, ST_WCNT, ST_A2, ST_A1, ST_A0: begin
                    if (accept_s) begin
                        cnt_r <= CNT_ZERO;
                        case (state_r)
                            ST_TAG: begin
                                tag_r   <= bus.rx_data;
                                state_r <= ST_WCNT;
                            end
                            ST_WCNT: begin
                                wcnt_r  <= bus.rx_data;
                                state_r <= ST_A2;
                            end
                            ST_A2: begin
                                addr_r[23:16] <= bus.rx_data;
                                state_r       <= ST_A1;
                            end
                            ST_A1: begin
                                addr_r[15:8] <= bus.rx_data;
                                state_r      <= ST_A0;
                            end
                            ST_A0: begin
                                addr_r[7:0]  <= bus.rx_data;
                                state_r      <= ST_HOLD;
                                rx_ready_r   <= 1'b0;
                                mreq_valid_r <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else if (expire_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_HOLD: begin
                    if (bus.mreq_ready) begin
                        mreq_valid_r <= 1'b0;
                        rx_ready_r   <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        mreq_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= CNT_ZERO;
                    rx_ready_r   <= 1'b1;
                    mreq_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready   = rx_ready_r;
    assign bus.mreq_valid = mreq_valid_r;
    assign bus.err        = err_r;
    assign bus.mreq_tag   = tag_r;
    assign bus.mreq_wr    = wr_r;
    assign bus.mreq_aincr = aincr_r;
    assign bus.mreq_wfmt  = wfmt_r;
    assign bus.mreq_wcnt  = wcnt_r;
    assign bus.mreq_addr  = addr_r;

endmodule

// File: tb/tb_cmd_rx.sv
// tb_cmd_rx: directed and randomized bench for cmd_rx. A frame-level
// reference model (byte queue + idle counter) predicts ready/valid/err and
// the decoded fields every cycle; directed steps add fixed expectations.
module tb_cmd_rx;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmd_rx_if ifc();
    cmd_rx #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_ready, m_hold, m_err;
    logic [7:0]  q[$];
    int          idle, m_reqs;
    logic [7:0]  e_tag, e_wcnt;
    logic        e_wr, e_aincr;
    logic [2:0]  e_wfmt;
    logic [23:0] e_addr;

    // observation counters
    int          obs_req, obs_err, valid_cyc, err_at, call_no, mr_low;
    bit          acc, mr_rand;
    logic [7:0]  h_tag, h_wcnt;
    logic        h_wr, h_aincr;
    logic [2:0]  h_wfmt;
    logic [23:0] h_addr;

    logic [7:0] basic [6] = '{8'hE1, 8'hAB, 8'hEC, 8'h12, 8'h34, 8'h56};
    logic [7:0] bp    [6] = '{8'hA2, 8'h33, 8'h76, 8'hAA, 8'hBB, 8'hCC};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0; m_hold = 1'b0; m_err = 1'b0;
        q.delete(); idle = 0;
        e_tag = 8'h00; e_wcnt = 8'h00; e_wr = 1'b0; e_aincr = 1'b0;
        e_wfmt = 3'b000; e_addr = 24'h000000;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit mr);
        logic [7:0] hdr;
        m_err = 1'b0;
        if (m_hold) begin
            if (mr) begin m_hold = 1'b0; m_reqs++; end
        end else if (m_ready && v) begin
            idle = 0;
            if (q.size() == 0) begin
                if (d[7] == 1'b1 && d[4:3] == 2'b00) q.push_back(d);
                else m_err = 1'b1;
            end else begin
                q.push_back(d);
                if (q.size() == 6) begin
                    hdr     = q[0];
                    e_wr    = hdr[6];
                    e_aincr = hdr[5];
                    e_wfmt  = hdr[2:0];
                    e_tag   = q[1];
                    e_wcnt  = q[2];
                    e_addr  = {q[3], q[4], q[5]};
                    m_hold  = 1'b1;
                    q.delete();
                end
            end
        end else if (q.size() != 0) begin
            idle++;
            if (idle == TO) begin q.delete(); idle = 0; m_err = 1'b1; end
        end
        m_ready = !m_hold;
    endtask

    task automatic check();
        chk("rx_ready", ifc.rx_ready, m_ready);
        chk("mreq_valid", ifc.mreq_valid, m_hold);
        chk("err", ifc.err, m_err);
        if (m_hold || rst) begin
            chk("tag", ifc.mreq_tag, e_tag);
            chk("wr", ifc.mreq_wr, e_wr);
            chk("aincr", ifc.mreq_aincr, e_aincr);
            chk("wfmt", ifc.mreq_wfmt, e_wfmt);
            chk("wcnt", ifc.mreq_wcnt, e_wcnt);
            chk("addr", ifc.mreq_addr, e_addr);
        end
    endtask

    // one clock: drive inputs, observe current cycle, advance model, check
    task automatic cycle(input bit v, input logic [7:0] d);
        bit mr;
        if (mr_low > 0) begin mr = 1'b0; mr_low--; end
        else if (mr_rand) mr = 1'($urandom_range(0, 1));
        else mr = 1'b1;
        ifc.rx_valid = v; ifc.rx_data = d; ifc.mreq_ready = mr;
        call_no++;
        acc = v && (ifc.rx_ready === 1'b1);
        if (ifc.mreq_valid === 1'b1) valid_cyc++;
        if (ifc.mreq_valid === 1'b1 && mr) begin
            obs_req++;
            h_tag = ifc.mreq_tag; h_wcnt = ifc.mreq_wcnt; h_wr = ifc.mreq_wr;
            h_aincr = ifc.mreq_aincr; h_wfmt = ifc.mreq_wfmt; h_addr = ifc.mreq_addr;
        end
        if (ifc.err === 1'b1) begin obs_err++; err_at = call_no; end
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(v, d, mr);
        #1;
        check();
    endtask

    task automatic send(input logic [7:0] b, input int gap, output int tries);
        repeat (gap) cycle(1'b0, 8'($urandom));
        tries = 0; acc = 1'b0;
        while (!acc && tries < 100) begin
            cycle(1'b1, b);
            tries++;
        end
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] f [6], input int gap);
        int t;
        for (int i = 0; i < 6; i++) send(f[i], gap, t);
    endtask

    task automatic clr();
        obs_req = 0; obs_err = 0; valid_cyc = 0; call_no = 0; err_at = -1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) cycle(1'b0, 8'($urandom));
    endtask

    task automatic chk_basic(input string tag);
        chk({tag, "_tag"}, h_tag, 8'hAB);
        chk({tag, "_wr"}, h_wr, 1'b1);
        chk({tag, "_aincr"}, h_aincr, 1'b1);
        chk({tag, "_wfmt"}, h_wfmt, 3'd1);
        chk({tag, "_wcnt"}, h_wcnt, 8'hEC);
        chk({tag, "_addr"}, h_addr, 24'h123456);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] f [6];
        rst = 1'b1;
        ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00; ifc.mreq_ready = 1'b0;
        mr_low = 0; mr_rand = 1'b0; m_reqs = 0;
        model_reset(); clr();
        #2;
        check();
        @(posedge clk); #1;
        check();
        rst = 1'b0;
        idle_n(2);

        // basic frame, back-to-back
        clr();
        send_frame(basic, 0);
        idle_n(3);
        chk("basic_req", obs_req, 1); chk("basic_err", obs_err, 0);
        chk("basic_vcyc", valid_cyc, 1);
        chk_basic("basic");

        // consumer backpressure with next HDR queued
        clr();
        send_frame(bp, 0);
        mr_low = 10;
        send(8'hE1, 0, t);
        chk("bp_hdr_tries", t, 12);
        chk("bp_vcyc", valid_cyc, 11);
        chk("bp_tag", h_tag, 8'h33); chk("bp_wr", h_wr, 1'b0);
        chk("bp_aincr", h_aincr, 1'b1); chk("bp_wfmt", h_wfmt, 3'd2);
        chk("bp_wcnt", h_wcnt, 8'h76); chk("bp_addr", h_addr, 24'hAABBCC);
        for (int i = 1; i < 6; i++) send(basic[i], 0, t);
        idle_n(3);
        chk("bp_req", obs_req, 2); chk("bp_err", obs_err, 0);
        chk_basic("bp2");

        // source stalls of 5 cycles between bytes
        clr();
        send_frame(basic, 5);
        idle_n(3);
        chk("stall_req", obs_req, 1); chk("stall_err", obs_err, 0);
        chk_basic("stall");

        // bad headers then a good frame
        clr();
        send(8'h7F, 0, t);
        send(8'hE8, 0, t);
        send_frame(basic, 0);
        idle_n(3);
        chk("badhdr_err", obs_err, 2); chk("badhdr_req", obs_req, 1);
        chk_basic("badhdr");

        // inter-byte timeout
        clr();
        send(8'hE1, 0, t); send(8'hAB, 0, t); send(8'hEC, 0, t);
        call_no = 0;
        idle_n(20);
        chk("to_err_at", err_at, 17);
        chk("to_err", obs_err, 1);
        send_frame(basic, 0);
        idle_n(3);
        chk("to_req", obs_req, 1); chk("to_err_total", obs_err, 1);
        chk_basic("to");

        // reset mid-frame
        clr();
        send(8'hE1, 0, t); send(8'hAB, 0, t); send(8'hEC, 0, t);
        rst = 1'b1;
        #1;
        model_reset();
        check();
        idle_n(2);
        rst = 1'b0;
        send_frame(basic, 0);
        idle_n(3);
        chk("rst_req", obs_req, 1); chk("rst_err", obs_err, 0);
        chk_basic("rst");

        // randomized frames, gaps, bad headers and consumer stalls
        clr();
        m_reqs = 0;
        mr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            f[0] = 8'($urandom) | 8'h80;
            f[0][4:3] = 2'b00;
            if ($urandom_range(0, 7) == 0) f[0] = 8'($urandom);
            for (int i = 1; i < 6; i++) f[i] = 8'($urandom);
            for (int i = 0; i < 6; i++)
                send(f[i], ($urandom_range(0, 15) == 0) ? 18 : int'($urandom_range(0, 3)), t);
        end
        mr_rand = 1'b0;
        idle_n(TO + 4);
        chk("rand_req", obs_req, m_reqs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
